regfile_scoreboard: RTL and testbench

Parametrised successor to the core's integer register file: N_READ combinational read ports, one write port, optional same-cycle write-to-read bypass, and a per-register pending (scoreboard) bit for in-flight writes. Sits in the decode stage of the pipelined RISC-V core. The issue logic reserves a destination at dispatch, and writeback clears it. Register x0 is hardwired to zero when ZERO_REG=1.

---
 rtl/regfile_scoreboard.sv | 80 ++++++++
 tb/tb_regfile_scoreboard.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file with N_READ combinational read ports, one write port, optional
// write-to-read bypass and a per-register pending bit set at dispatch and cleared at writeback.
module regfile_scoreboard #(
    parameter int unsigned N_DATA     = 32,
    parameter int unsigned N_REG_ADDR = 5,
    parameter int unsigned N_READ     = 2,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_READ-1:0][N_REG_ADDR-1:0]    read_addr,
    output logic [N_READ-1:0][N_DATA-1:0]        read_data,
    output logic [N_READ-1:0]                    read_pending,
    input  logic                                 write_enable,
    input  logic [N_REG_ADDR-1:0]                write_addr,
    input  logic [N_DATA-1:0]                    write_data,
    input  logic                                 reserve_enable,
    input  logic [N_REG_ADDR-1:0]                reserve_addr,
    input  logic                                 flush,
    output logic                                 any_pending
);

    localparam int unsigned Depth = 1 << N_REG_ADDR;

    logic [N_DATA-1:0] regs_q [Depth];
    logic [Depth-1:0]  pend_q, pend_d;
    logic              wr_en, rsv_en;

    // x0 swallows writes and reserves so it can never hold data or become pending.
    assign wr_en  = write_enable   && !((ZERO_REG != 0) && (write_addr == '0));
    assign rsv_en = reserve_enable && !((ZERO_REG != 0) && (reserve_addr == '0));

    // Order matters: a reserve beats a same-cycle write, and flush beats both.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[write_addr] = 1'b0;
        end
        if (rsv_en) begin
            pend_d[reserve_addr] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            if (wr_en) begin
                regs_q[write_addr] <= write_data;
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < N_READ; k++) begin
            read_data[k]    = regs_q[read_addr[k]];
            read_pending[k] = pend_q[read_addr[k]];
            // Storage is already zero during reset; only the bypass path needs gating.
            if ((BYPASS != 0) && rst && write_enable && (write_addr == read_addr[k])) begin
                read_data[k]    = write_data;
                read_pending[k] = 1'b0;
            end
            if ((ZERO_REG != 0) && (read_addr[k] == '0)) begin
                read_data[k]    = '0;
                read_pending[k] = 1'b0;
            end
        end
    end

    assign any_pending = |pend_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: a bypassing and a non-bypassing instance share all stimulus; expected
// read results are queued as stimulus is driven and popped when the outputs are sampled.
module tb_regfile_scoreboard;

    logic            clk;
    logic            rst;
    logic [1:0][4:0] read_addr;
    logic            write_enable;
    logic [4:0]      write_addr;
    logic [31:0]     write_data;
    logic            reserve_enable;
    logic [4:0]      reserve_addr;
    logic            flush;

    logic [1:0][31:0] rd_b, rd_n;
    logic [1:0]       rp_b, rp_n;
    logic             ap_b, ap_n;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] model_regs [32];
    logic [32:0] exp_q [$];   // {pending, data}

    regfile_scoreboard #(.N_DATA(32), .N_REG_ADDR(5), .N_READ(2), .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(rd_b), .read_pending(rp_b),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .flush(flush),
        .any_pending(ap_b)
    );

    regfile_scoreboard #(.N_DATA(32), .N_REG_ADDR(5), .N_READ(2), .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst(rst), .read_addr(read_addr), .read_data(rd_n), .read_pending(rp_n),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .reserve_enable(reserve_enable), .reserve_addr(reserve_addr), .flush(flush),
        .any_pending(ap_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_enable   = 1'b0;
        reserve_enable = 1'b0;
        flush          = 1'b0;
    endtask

    // Pops one expected {pend,data} per port and compares both instances against it.
    task automatic pop_and_compare(input string tag);
        logic [32:0] e;
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_cmp += 2;
            if (rd_b[k] !== e[31:0] || rp_b[k] !== e[32]) begin
                n_err++;
                $display("FAIL %s bypass port%0d: got data=%h pend=%b, want data=%h pend=%b",
                         tag, k, rd_b[k], rp_b[k], e[31:0], e[32]);
            end
            if (rd_n[k] !== e[31:0] || rp_n[k] !== e[32]) begin
                n_err++;
                $display("FAIL %s nobypass port%0d: got data=%h pend=%b, want data=%h pend=%b",
                         tag, k, rd_n[k], rp_n[k], e[31:0], e[32]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        read_addr[0] = 5'd5;
        read_addr[1] = 5'd31;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        next_cycle();
        next_cycle();
        exp_q.push_back(33'h0);
        exp_q.push_back(33'h0);
        pop_and_compare("reset_read");
        n_cmp++;
        if (ap_b !== 1'b0 || ap_n !== 1'b0) begin
            n_err++;
            $display("FAIL reset_any_pending: got %b/%b, want 0/0", ap_b, ap_n);
        end
        rst = 1'b1;
    endtask

    task automatic test_fill();
        for (int r = 0; r < 32; r++) begin
            next_cycle();
            write_enable = 1'b1;
            write_addr   = 5'(r);
            write_data   = $urandom();
            if (r != 0) model_regs[r] = write_data;
        end
        next_cycle();
        idle_inputs();
        #1;
        for (int r = 0; r < 32; r++) begin
            read_addr[0] = 5'(r);
            read_addr[1] = 5'(31 - r);
            exp_q.push_back({1'b0, model_regs[r]});
            exp_q.push_back({1'b0, model_regs[31 - r]});
            #1;
            pop_and_compare("fill_read");
        end
    endtask

    task automatic test_bypass();
        logic [31:0] old7;
        old7 = model_regs[7];
        next_cycle();
        write_enable = 1'b1;
        write_addr   = 5'd7;
        write_data   = 32'hDEAD_BEEF;
        read_addr[0] = 5'd7;
        read_addr[1] = 5'd7;
        #2;
        n_cmp += 2;
        if (rd_b[0] !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL bypass_same_cycle: got %h, want deadbeef", rd_b[0]);
        end
        if (rd_n[1] !== old7) begin
            n_err++;
            $display("FAIL nobypass_same_cycle: got %h, want %h", rd_n[1], old7);
        end
        next_cycle();
        idle_inputs();
        model_regs[7] = 32'hDEAD_BEEF;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        #1;
        pop_and_compare("bypass_next_cycle");
    endtask

    task automatic test_scoreboard();
        logic [31:0] old5;
        old5 = model_regs[5];
        next_cycle();
        reserve_enable = 1'b1;
        reserve_addr   = 5'd5;
        read_addr[0]   = 5'd5;
        read_addr[1]   = 5'd6;
        exp_q.push_back({1'b0, old5});
        exp_q.push_back({1'b0, model_regs[6]});
        #1;
        pop_and_compare("reserve_before_edge");
        next_cycle();
        idle_inputs();
        exp_q.push_back({1'b1, old5});
        exp_q.push_back({1'b0, model_regs[6]});
        #1;
        pop_and_compare("reserve_after_edge");
        n_cmp++;
        if (ap_b !== 1'b1 || ap_n !== 1'b1) begin
            n_err++;
            $display("FAIL reserve_any_pending: got %b/%b, want 1/1", ap_b, ap_n);
        end
        write_enable = 1'b1;
        write_addr   = 5'd5;
        write_data   = 32'h0000_1234;
        #1;
        n_cmp += 3;
        if (rd_b[0] !== 32'h1234 || rp_b[0] !== 1'b0) begin
            n_err++;
            $display("FAIL writeback_bypass: got data=%h pend=%b, want 00001234/0", rd_b[0], rp_b[0]);
        end
        if (rd_n[0] !== old5 || rp_n[0] !== 1'b1) begin
            n_err++;
            $display("FAIL writeback_nobypass: got data=%h pend=%b, want %h/1", rd_n[0], rp_n[0], old5);
        end
        if (ap_b !== 1'b1) begin
            n_err++;
            $display("FAIL writeback_any_before_edge: got %b, want 1", ap_b);
        end
        next_cycle();
        idle_inputs();
        model_regs[5] = 32'h1234;
        exp_q.push_back({1'b0, 32'h1234});
        exp_q.push_back({1'b0, model_regs[6]});
        #1;
        pop_and_compare("writeback_after_edge");
        n_cmp++;
        if (ap_b !== 1'b0 || ap_n !== 1'b0) begin
            n_err++;
            $display("FAIL writeback_any_pending: got %b/%b, want 0/0", ap_b, ap_n);
        end
    endtask

    task automatic test_collisions();
        // Reserve and write x9 together: data lands, pending stays set.
        next_cycle();
        write_enable   = 1'b1;
        write_addr     = 5'd9;
        write_data     = 32'h0000_0099;
        reserve_enable = 1'b1;
        reserve_addr   = 5'd9;
        next_cycle();
        idle_inputs();
        model_regs[9] = 32'h99;
        read_addr[0] = 5'd9;
        read_addr[1] = 5'd3;
        exp_q.push_back({1'b1, 32'h99});
        exp_q.push_back({1'b0, model_regs[3]});
        #1;
        pop_and_compare("reserve_write_same");
        // Flush with reserve x3 and write x10: reserve dropped, x9 cleared, write kept.
        flush          = 1'b1;
        reserve_enable = 1'b1;
        reserve_addr   = 5'd3;
        write_enable   = 1'b1;
        write_addr     = 5'd10;
        write_data     = 32'h0000_0ABC;
        next_cycle();
        idle_inputs();
        model_regs[10] = 32'hABC;
        read_addr[1] = 5'd10;
        exp_q.push_back({1'b0, 32'h99});
        exp_q.push_back({1'b0, 32'hABC});
        #1;
        pop_and_compare("flush_collision");
        read_addr[0] = 5'd3;
        exp_q.push_back({1'b0, model_regs[3]});
        exp_q.push_back({1'b0, 32'hABC});
        #1;
        pop_and_compare("flush_drops_reserve");
        n_cmp++;
        if (ap_b !== 1'b0 || ap_n !== 1'b0) begin
            n_err++;
            $display("FAIL flush_any_pending: got %b/%b, want 0/0", ap_b, ap_n);
        end
        // x0: reserve and write ignored, zero even on the bypass path.
        reserve_enable = 1'b1;
        reserve_addr   = 5'd0;
        write_enable   = 1'b1;
        write_addr     = 5'd0;
        write_data     = 32'hFFFF_FFFF;
        read_addr[0]   = 5'd0;
        read_addr[1]   = 5'd0;
        exp_q.push_back(33'h0);
        exp_q.push_back(33'h0);
        #1;
        pop_and_compare("x0_bypass");
        next_cycle();
        idle_inputs();
        exp_q.push_back(33'h0);
        exp_q.push_back(33'h0);
        #1;
        pop_and_compare("x0_after_edge");
        n_cmp++;
        if (ap_b !== 1'b0 || ap_n !== 1'b0) begin
            n_err++;
            $display("FAIL x0_any_pending: got %b/%b, want 0/0", ap_b, ap_n);
        end
    endtask

    task automatic test_back_to_back();
        // Consecutive writes to neighbours while reading the previous one each cycle.
        for (int i = 11; i < 15; i++) begin
            next_cycle();
            write_enable = 1'b1;
            write_addr   = 5'(i);
            write_data   = 32'hC0DE_0000 + 32'(i);
            read_addr[0] = 5'(i - 1);
            read_addr[1] = 5'(i - 1);
            exp_q.push_back({1'b0, model_regs[i - 1]});
            exp_q.push_back({1'b0, model_regs[i - 1]});
            #1;
            pop_and_compare("back_to_back");
            model_regs[i] = write_data;
        end
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        next_cycle();
        write_enable = 1'b1;
        write_addr   = 5'd4;
        write_data   = 32'h0000_00A5;
        next_cycle();
        idle_inputs();
        reserve_enable = 1'b1;
        reserve_addr   = 5'd4;
        next_cycle();
        idle_inputs();
        read_addr[0] = 5'd4;
        read_addr[1] = 5'd14;
        exp_q.push_back({1'b1, 32'hA5});
        exp_q.push_back({1'b0, model_regs[14]});
        #1;
        pop_and_compare("pre_reset_state");
        // Mid-cycle reset; a write is also presented to prove bypass is gated.
        write_enable = 1'b1;
        write_addr   = 5'd4;
        write_data   = 32'h5555_5555;
        rst          = 1'b0;
        #1;
        exp_q.push_back(33'h0);
        exp_q.push_back(33'h0);
        pop_and_compare("async_reset");
        n_cmp++;
        if (ap_b !== 1'b0 || ap_n !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_any_pending: got %b/%b, want 0/0", ap_b, ap_n);
        end
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 32; i++) model_regs[i] = '0;
        // First edge after release is a normal operating edge.
        write_enable = 1'b1;
        write_addr   = 5'd14;
        write_data   = 32'h1414_1414;
        next_cycle();
        idle_inputs();
        exp_q.push_back(33'h0);
        exp_q.push_back({1'b0, 32'h1414_1414});
        #1;
        pop_and_compare("post_reset_write");
    endtask

    initial begin
        read_addr  = '0;
        write_addr = '0;
        write_data = '0;
        reserve_addr = '0;
        test_reset();
        test_fill();
        test_bypass();
        test_scoreboard();
        test_collisions();
        test_back_to_back();
        test_async_reset();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
